// File: rtl/alu_issue_if.sv
// Interface bundle for alu_issue: instruction handshake, ALU drive/return,
// writeback and the debug register-read port.
interface alu_issue_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [3:0]  alu_op;
  logic [31:0] alu_left;
  logic [31:0] alu_right;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  dbg_sel;
  logic [31:0] dbg_data;

  // Issue/writeback controller side
  modport slave (
    input  inst_valid, inst, alu_result, dbg_sel,
    output inst_ready, alu_op, alu_left, alu_right,
           wb_valid, wb_rd, wb_data, dbg_data
  );

  // Decode stage / ALU / debug side
  modport master (
    output inst_valid, inst, alu_result, dbg_sel,
    input  inst_ready, alu_op, alu_left, alu_right,
           wb_valid, wb_rd, wb_data, dbg_data
  );
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback controller for the CPU32 combinational ALU: latches operands
// from a 16x32 register file, holds them for the ALU, and writes the result back.
module alu_issue #(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  alu_issue_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_MWAIT = 2'd2,
    S_WB    = 2'd3
  } state_t;

  localparam logic [3:0] OP_MUL   = 4'hF;
  localparam logic [3:0] MUL_LOAD = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_regs [16];
  logic [3:0]  r_op;
  logic [3:0]  r_rd;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic [31:0] r_left;
  logic [31:0] r_right;
  logic [31:0] r_result;
  logic        w_capture;
  logic        w_ready;
  logic        w_accept;
  logic        w_wb;

  logic [3:0]  w_op;
  logic [3:0]  w_rd;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic        w_immsel;
  logic [31:0] w_imm;
  logic [31:0] w_ra_val;
  logic [31:0] w_rb_val;

  assign w_op     = bus.inst[31:28];
  assign w_rd     = bus.inst[27:24];
  assign w_ra     = bus.inst[23:20];
  assign w_rb     = bus.inst[19:16];
  assign w_immsel = bus.inst[15];
  assign w_imm    = {{17{bus.inst[14]}}, bus.inst[14:0]};

  assign w_wb     = (r_state == S_WB);
  assign w_ready  = reset_n && ((r_state == S_IDLE) || (r_state == S_WB));
  assign w_accept = bus.inst_valid && w_ready;

  // An accept in the WB cycle must see the value being written on that same edge.
  always_comb begin
    w_ra_val = r_regs[w_ra];
    w_rb_val = r_regs[w_rb];
    if (w_wb && (r_rd != 4'd0) && (w_ra == r_rd)) begin
      w_ra_val = r_result;
    end
    if (w_wb && (r_rd != 4'd0) && (w_rb == r_rd)) begin
      w_rb_val = r_result;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if ((r_op == OP_MUL) && (MUL_CYCLES > 1)) begin
          w_cnt_next   = MUL_LOAD;
          w_state_next = S_MWAIT;
        end else begin
          w_capture    = 1'b1;
          w_state_next = S_WB;
        end
      end
      S_MWAIT: begin
        if (r_cnt == 4'd0) begin
          w_capture    = 1'b1;
          w_state_next = S_WB;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_WB: begin
        w_state_next = w_accept ? S_EXEC : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_op     <= 4'd0;
      r_rd     <= 4'd0;
      r_left   <= 32'd0;
      r_right  <= 32'd0;
      r_result <= 32'd0;
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_capture) begin
        r_result <= bus.alu_result;
      end
      if (w_accept) begin
        r_op    <= w_op;
        r_rd    <= w_rd;
        r_left  <= w_ra_val;
        r_right <= w_immsel ? w_imm : w_rb_val;
      end
      // r0 is never written, so it keeps its reset value of zero.
      if (w_wb && (r_rd != 4'd0)) begin
        r_regs[r_rd] <= r_result;
      end
    end
  end

  assign bus.inst_ready = w_ready;
  assign bus.alu_op     = r_op;
  assign bus.alu_left   = r_left;
  assign bus.alu_right  = r_right;
  assign bus.wb_valid   = w_wb;
  assign bus.wb_rd      = r_rd;
  assign bus.wb_data    = r_result;
  assign bus.dbg_data   = r_regs[bus.dbg_sel];

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: vector table, directed corner sequences
// and a random run checked against an in-order architectural model.
module tb_alu_issue;
  localparam int unsigned MULC = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  alu_issue_if bus ();

  alu_issue #(.MUL_CYCLES(MULC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] l, input logic [31:0] r);
    case (op)
      4'h0, 4'h2: return l + r;
      4'h1:       return l - r;
      4'h3:       return l & r;
      4'h4:       return l | r;
      4'h5:       return l ^ r;
      4'hF:       return l * r;
      default:    return l ^ {r[15:0], r[31:16]};
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_op, bus.alu_left, bus.alu_right);

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic immsel, input logic [14:0] imm);
    return {op, rd, ra, rb, immsel, imm};
  endfunction

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural model: instructions complete in acceptance order
  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mreg [16];
  logic [3:0]  cur_op;
  logic [31:0] cur_l;
  logic [31:0] cur_r;

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      for (int i = 0; i < 16; i++) mreg[i] = 32'd0;
      cur_op = 4'd0;
      cur_l  = 32'd0;
      cur_r  = 32'd0;
    end else begin
      check("alu_inputs", {cur_op, cur_l, cur_r}, {bus.alu_op, bus.alu_left, bus.alu_right});
      if (bus.wb_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: got wb_rd=%0d wb_data=%h, required no writeback", bus.wb_rd, bus.wb_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("wb_rd", bus.wb_rd, e.rd);
          check("wb_data", bus.wb_data, e.data);
          check("wb_latency", cyc - e.acc, e.lat);
        end
      end else if (q.size() > 0 && (cyc - q[0].acc) > q[0].lat) begin
        tests++;
        fails++;
        $display("FAIL wb_missing: no writeback for rd=%0d, required within %0d cycles", q[0].rd, q[0].lat);
        void'(q.pop_front());
      end
      if (bus.inst_valid && bus.inst_ready) begin
        exp_t        e;
        logic [31:0] w;
        logic [31:0] l;
        logic [31:0] r;
        w = bus.inst;
        l = mreg[w[23:20]];
        r = w[15] ? {{17{w[14]}}, w[14:0]} : mreg[w[19:16]];
        e.rd   = w[27:24];
        e.data = alu_f(w[31:28], l, r);
        e.acc  = cyc;
        e.lat  = ((w[31:28] == 4'hF) ? int'(MULC) : 1) + 1;
        q.push_back(e);
        if (e.rd != 4'd0) mreg[e.rd] = e.data;
        cur_op = w[31:28];
        cur_l  = l;
        cur_r  = r;
      end
    end
  end

  task automatic issue(input logic [31:0] word);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.inst_valid = 1'b1;
    bus.inst = word;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.inst_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: inst_ready=0 for 50 cycles, required 1");
    end
    @(posedge clk);
    #1;
    bus.inst_valid = 1'b0;
  endtask

  task automatic wait_wb();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.wb_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL wb_timeout: wb_valid=0 for 40 cycles, required 1");
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (q.size() == 0 && bus.inst_ready && !bus.wb_valid) break;
    end
  endtask

  task automatic check_regs_zero(input string name);
    for (int i = 0; i < 16; i++) begin
      bus.dbg_sel = 4'(i);
      #1;
      check(name, bus.dbg_data, 32'd0);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        immsel;
    logic [14:0] imm;
    logic [31:0] exp_left;
    logic [31:0] exp_right;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'h2, 4'd1,  4'd0, 4'd0,  1'b1, 15'h7FFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[1]  = '{4'h0, 4'd0,  4'd0, 4'd0,  1'b1, 15'h0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001};
    vecs[2]  = '{4'h2, 4'd4,  4'd0, 4'd0,  1'b1, 15'h0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[3]  = '{4'h2, 4'd5,  4'd1, 4'd0,  1'b1, 15'h0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[4]  = '{4'h2, 4'd6,  4'd0, 4'd0,  1'b1, 15'h4000, 32'h0000_0000, 32'hFFFF_C000, 32'hFFFF_C000};
    vecs[5]  = '{4'h2, 4'd7,  4'd0, 4'd0,  1'b1, 15'h3FFF, 32'h0000_0000, 32'h0000_3FFF, 32'h0000_3FFF};
    vecs[6]  = '{4'h1, 4'd8,  4'd7, 4'd6,  1'b0, 15'h7ABC, 32'h0000_3FFF, 32'hFFFF_C000, 32'h0000_7FFF};
    vecs[7]  = '{4'hF, 4'd9,  4'd7, 4'd8,  1'b0, 15'h0000, 32'h0000_3FFF, 32'h0000_7FFF, 32'h1FFF_4001};
    vecs[8]  = '{4'h3, 4'd10, 4'd1, 4'd7,  1'b0, 15'h0000, 32'hFFFF_FFFF, 32'h0000_3FFF, 32'h0000_3FFF};
    vecs[9]  = '{4'h5, 4'd11, 4'd6, 4'd7,  1'b0, 15'h0000, 32'hFFFF_C000, 32'h0000_3FFF, 32'hFFFF_FFFF};
    vecs[10] = '{4'h4, 4'd15, 4'd6, 4'd0,  1'b1, 15'h00FF, 32'hFFFF_C000, 32'h0000_00FF, 32'hFFFF_C0FF};
    vecs[11] = '{4'h2, 4'd1,  4'd1, 4'd15, 1'b0, 15'h0000, 32'hFFFF_FFFF, 32'hFFFF_C0FF, 32'hFFFF_C0FE};

    bus.inst_valid = 1'b0;
    bus.inst = 32'd0;
    bus.dbg_sel = 4'd0;

    // Reset behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", bus.inst_ready, 1'b0);
    check("wb_valid_in_reset", bus.wb_valid, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus.inst_ready, 1'b1);
    check("outputs_after_reset", {bus.wb_valid, bus.wb_rd, bus.wb_data, bus.alu_op, bus.alu_left, bus.alu_right}, '0);
    check_regs_zero("dbg_after_reset");

    // Vector table, one instruction at a time
    for (int i = 0; i < 12; i++) begin
      issue(mk(vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb, vecs[i].immsel, vecs[i].imm));
      @(negedge clk);
      check($sformatf("vec%0d_left", i), bus.alu_left, vecs[i].exp_left);
      check($sformatf("vec%0d_right", i), bus.alu_right, vecs[i].exp_right);
      if (vecs[i].op != 4'hF) @(negedge clk);
      else wait_wb();
      check($sformatf("vec%0d_wb_valid", i), bus.wb_valid, 1'b1);
      check($sformatf("vec%0d_wb_rd", i), bus.wb_rd, vecs[i].rd);
      check($sformatf("vec%0d_wb_data", i), bus.wb_data, vecs[i].exp_wb);
      @(negedge clk);
      bus.dbg_sel = vecs[i].rd;
      #1;
      check($sformatf("vec%0d_dbg", i), bus.dbg_data, (vecs[i].rd == 4'd0) ? 32'd0 : vecs[i].exp_wb);
      $display("[TB] vec %0d op=%h rd=%0d wb=%h", i, vecs[i].op, vecs[i].rd, bus.wb_data);
    end
    wait_idle();

    // Back-to-back with inst_valid held; second operand forwarded from WB
    @(posedge clk);
    #1;
    bus.inst_valid = 1'b1;
    bus.inst = mk(4'h2, 4'd1, 4'd0, 4'd0, 1'b1, 15'd5);
    @(negedge clk);
    check("b2b_ready_idle", bus.inst_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.inst = mk(4'h2, 4'd2, 4'd1, 4'd0, 1'b1, 15'd3);
    @(negedge clk);
    check("b2b_ready_exec", bus.inst_ready, 1'b0);
    @(negedge clk);
    check("b2b_wb1", {bus.wb_valid, bus.wb_rd, bus.wb_data, bus.inst_ready}, {1'b1, 4'd1, 32'd5, 1'b1});
    @(posedge clk);
    #1;
    bus.inst_valid = 1'b0;
    @(negedge clk);
    check("b2b_fwd_left", bus.alu_left, 32'd5);
    check("b2b_right", bus.alu_right, 32'd3);
    check("b2b_ready_exec2", bus.inst_ready, 1'b0);
    @(negedge clk);
    check("b2b_wb2", {bus.wb_valid, bus.wb_rd, bus.wb_data}, {1'b1, 4'd2, 32'd8});
    $display("[TB] back-to-back r1=5 r2=%0d", bus.wb_data);
    wait_idle();

    // Multiply holds inputs for MUL_CYCLES cycles
    issue(mk(4'h2, 4'd1, 4'd0, 4'd0, 1'b1, 15'd7));
    wait_idle();
    issue(mk(4'h2, 4'd2, 4'd0, 4'd0, 1'b1, 15'd6));
    wait_idle();
    @(posedge clk);
    #1;
    bus.inst_valid = 1'b1;
    bus.inst = mk(4'hF, 4'd3, 4'd1, 4'd2, 1'b0, 15'd0);
    @(negedge clk);
    check("mul_ready_before", bus.inst_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.inst = $urandom;
    for (int k = 0; k < int'(MULC); k++) begin
      @(negedge clk);
      check($sformatf("mul_hold%0d", k), {bus.inst_ready, bus.wb_valid, bus.alu_op, bus.alu_left, bus.alu_right},
            {1'b0, 1'b0, 4'hF, 32'd7, 32'd6});
    end
    bus.inst_valid = 1'b0;
    @(negedge clk);
    check("mul_wb", {bus.wb_valid, bus.wb_rd, bus.wb_data}, {1'b1, 4'd3, 32'd42});
    $display("[TB] multiply 7*6 wb=%0d", bus.wb_data);
    wait_idle();

    // Reset during MWAIT discards the multiply
    issue(mk(4'hF, 4'd9, 4'd1, 4'd2, 1'b0, 15'd0));
    @(negedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_outputs", {bus.inst_ready, bus.wb_valid, bus.alu_op, bus.alu_left, bus.alu_right}, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_mid_no_wb", bus.wb_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", bus.inst_ready, 1'b1);
    check_regs_zero("rst_mid_regs");
    issue(mk(4'h2, 4'd3, 4'd1, 4'd0, 1'b1, 15'd9));
    @(negedge clk);
    check("post_rst_left", bus.alu_left, 32'd0);
    @(negedge clk);
    check("post_rst_wb", {bus.wb_valid, bus.wb_rd, bus.wb_data}, {1'b1, 4'd3, 32'd9});
    $display("[TB] reset during multiply, next wb=%0d", bus.wb_data);
    wait_idle();

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] op;
      @(posedge clk);
      #1;
      case ($urandom_range(0, 7))
        0: op = 4'hF;
        1: op = 4'h1;
        2: op = 4'h3;
        3: op = 4'h5;
        4: op = 4'(  $urandom_range(6, 14));
        default: op = 4'h2;
      endcase
      bus.inst_valid = ($urandom_range(0, 3) != 0);
      bus.inst = mk(op, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 15'($urandom));
    end
    @(posedge clk);
    #1;
    bus.inst_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      bus.dbg_sel = 4'(i);
      #1;
      check($sformatf("rand_reg%0d", i), bus.dbg_data, mreg[i]);
    end
    $display("[TB] random run done, r1=%h", mreg[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Issue/writeback controller that drives the CPU32 ALU from the initiator side. It accepts 32-bit ALU instructions over a valid/ready handshake and reads operands from an internal 16x32 register file. It presents opcode and operands to the external ALU, holds them stable for the required number of cycles, captures the combinational result and writes it back. It sits between instruction decode and the ALU in the execute stage.

## Interface
- MUL_CYCLES, default 3: cycles ALU inputs are held for opcode 4'b1111 (multiply); legal range 1..15.
- clk  in  1  sole clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- inst_valid  in  1  instruction word available.
- inst_ready  out  1  block can accept; transfer when inst_valid && inst_ready on a rising edge.
- inst  in  32  instruction: [31:28] ALU opcode, [27:24] rd, [23:20] ra, [19:16] rb, [15] immsel, [14:0] imm15.
- alu_op  out  4  opcode to ALU.
- alu_left  out  32  left operand to ALU.
- alu_right  out  32  right operand to ALU.
- alu_result  in  32  combinational ALU output for current alu_op/left/right.
- wb_valid  out  1  one-cycle pulse: a result is being written this cycle.
- wb_rd  out  4  destination register of the write.
- wb_data  out  32  value being written.
- dbg_sel  in  4  debug read register index.
- dbg_data  out  32  combinational read of register dbg_sel (r0 reads 0).

## Operation
- Register file: 16 x 32, r0 hardwired zero; writes to r0 are dropped, but wb_valid still pulses with wb_rd=0.
- Operand formation at acceptance: left = R[ra]; right = immsel ? sign-extend(imm15) to 32 bits : R[rb].
- Forwarding: if acceptance coincides with a WB cycle and ra (or rb when immsel=0) equals wb_rd != 0, the operand takes wb_data, not the stale register.
- Opcode passes through unmodified. The block never interprets it except to detect 4'b1111.
- States:
  - IDLE: inst_ready=1. On accept, go to EXEC.
  - EXEC: inst_ready=0, ALU inputs driven from latched operands. Non-multiply: capture alu_result into the result register, go to WB. Multiply with MUL_CYCLES=1: same. Multiply with MUL_CYCLES>1: load counter with MUL_CYCLES-2, go to MWAIT.
  - MWAIT: inputs held stable, inst_ready=0. If counter==0, capture alu_result and go to WB; else decrement.
  - WB: wb_valid=1, register write occurs on this edge, inst_ready=1. On accept, go to EXEC; otherwise go to IDLE.
- alu_op/alu_left/alu_right hold the last latched values in IDLE and WB; they change only on acceptance.
- An instruction is never dropped or duplicated: exactly one wb_valid pulse per accepted instruction, in acceptance order.

## Timing
- Reset (asserted at any time, including mid-multiply): state to IDLE; all registers R1..R15, the latched operands, alu_op, result register and counter to 0. Outputs: inst_ready=0 while reset_n low, 1 from the first cycle after release; wb_valid=0, wb_rd=0, wb_data=0, alu_op=0, alu_left=0, alu_right=0. The in-flight instruction is discarded with no writeback.
- Latency, non-multiply: accept at edge N, EXEC cycle N..N+1, wb_valid high in cycle N+1..N+2, register visible on dbg_data from edge N+2.
- Latency, multiply: wb_valid is high MUL_CYCLES cycles after acceptance (EXEC plus MUL_CYCLES-1 MWAIT cycles).
- Throughput: back-to-back non-multiply instructions are accepted every 2 cycles (accept in IDLE/WB, then EXEC).
- inst_valid may be held with inst changing while inst_ready=0. Only the word present at the accepting edge is used.
- dbg_data is combinational from the register array. It does not forward; it shows the new value after the WB edge.

## Test plan
- Reset release, inst_valid=0 -> all outputs 0, inst_ready=1 from first post-reset cycle, dbg_data=0 for every dbg_sel.
- Accept op 4'b0010, rd=1, ra=0, immsel=1, imm15=15'h7FFF -> alu_left=0, alu_right=32'hFFFFFFFF. With ALU model attached, wb_valid with wb_rd=1, wb_data=32'hFFFFFFFF two cycles after accept; dbg_sel=1 then reads 32'hFFFFFFFF.
- Back-to-back with inst_valid held: r1=5 (imm), then op 4'b0010 rd=2 ra=1 imm=3 accepted during r1's WB cycle -> forwarded alu_left=5, r2=8, one accept every 2 cycles.
- Multiply, MUL_CYCLES=3: r1=7, r2=6, op 4'b1111 rd=3 ra=1 rb=2 -> inputs stable 3 cycles, inst_ready=0 throughout, wb_data=42 on cycle 3 after accept.
- Write to r0 (op 4'b0000 imm=1, rd=0) -> wb_valid=1, wb_rd=0; dbg_sel=0 still reads 0; a later instruction with ra=0 sees alu_left=0.
- Assert reset_n low during MWAIT -> no wb_valid pulse, all registers read 0 after release, next instruction executes normally.
